imem_loader: RTL and testbench

Boot-time writer for the fetch-stage instruction memory. It accepts a byte stream over a valid/ready handshake and stores it into a 256-byte, byte-addressed array. The fetch stage reads the same array as big-endian 32-bit words. While loading, the block holds the pipeline in reset so the PC starts from address 0 once the program is in place. This replaces testbench-side preloading of the instruction ROM.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time byte-stream loader for the fetch-stage instruction memory.
// Holds the pipeline in reset while a program is streamed into the array.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] A,
  output logic [31:0]       I,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH-1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              xfer;
  logic              restart;
  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] a1, a2, a3;

  assign xfer    = (state_q == S_LOAD) && in_valid;
  assign restart = (state_q != S_LOAD) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          if (in_last)
            state_d = S_RUN;
          else if (cnt_q == CNT_LAST)
            state_d = S_ERR;
        end
      end
      S_RUN: begin
        if (start) state_d = S_LOAD;
      end
      S_ERR: begin
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (restart) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (xfer) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      cnt_d    = cnt_q + (ADDR_W+1)'(1);
    end
  end

  // Storage is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && xfer)
      mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    overflow = 1'b0;
    unique case (1'b1)
      (state_q == S_LOAD): in_ready = 1'b1;
      (state_q == S_RUN): begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      (state_q == S_ERR): overflow = 1'b1;
      default: ;
    endcase
  end

  assign byte_count = cnt_q;

  assign a1 = A + ADDR_W'(1);
  assign a2 = A + ADDR_W'(2);
  assign a3 = A + ADDR_W'(3);

  assign I = {mem_q[A], mem_q[a1], mem_q[a2], mem_q[a3]};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  A;
  logic [31:0] I;
  logic        cpu_hold;
  logic        done;
  logic        overflow;
  logic [8:0]  byte_count;

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .A(A),
    .I(I),
    .cpu_hold(cpu_hold),
    .done(done),
    .overflow(overflow),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  localparam int K_STAT = 0;
  localparam int K_CNT  = 1;
  localparam int K_WORD = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   nchecks = 0;
  int   nerr = 0;

  logic [7:0] mem_m [256];
  logic [7:0] mptr;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = '0;
      case (e.kind)
        K_STAT: act = {28'd0, in_ready, cpu_hold, done, overflow};
        K_CNT:  act = {23'd0, byte_count};
        default: act = I;
      endcase
      nchecks++;
      if (act !== e.exp) begin
        nerr++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_stat(input string n, input logic rdy, input logic hold,
                          input logic dn, input logic ov);
    chk_t e;
    e.name = n;
    e.kind = K_STAT;
    e.exp = {28'd0, rdy, hold, dn, ov};
    q.push_back(e);
  endtask

  task automatic exp_cnt(input string n, input int c);
    chk_t e;
    e.name = n;
    e.kind = K_CNT;
    e.exp = 32'(c);
    q.push_back(e);
  endtask

  task automatic exp_word(input string n, input logic [7:0] a,
                          input logic [31:0] w);
    chk_t e;
    A = a;
    e.name = n;
    e.kind = K_WORD;
    e.exp = w;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {mem_m[a], mem_m[b1], mem_m[b2], mem_m[b3]};
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    mem_m[mptr] = d;
    mptr = mptr + 8'd1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mptr = 8'd0;
  endtask

  logic [7:0] prog [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 8'hE2; prog[1] = 8'h11; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'hE0; prog[5] = 8'h80; prog[6] = 8'h51; prog[7] = 8'h83;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    A = 8'h00;
    mptr = 8'd0;
    tick();
    tick();
    exp_stat("reset_stat", 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cnt("reset_cnt", 0);
    reset = 1'b0;
    tick();
    exp_stat("idle_stat", 1'b0, 1'b1, 1'b0, 1'b0);

    // Basic 8-byte program
    do_start();
    exp_stat("t1_load", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(prog[i], i == 7);
      if (i == 6) exp_stat("t1_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    exp_stat("t1_run", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt("t1_cnt", 8);
    exp_word("t1_w0", 8'd0, 32'hE2110000);
    exp_word("t1_w4", 8'd4, 32'hE0805183);
    exp_word("t1_w2", 8'd2, 32'h0000E080);

    // Same program with gaps; last asserted on idle cycles must be ignored
    tick();
    do_start();
    for (int i = 0; i < 8; i++) begin
      send(prog[i], i == 7);
      if (i != 7) begin
        in_last = 1'b1;
        in_data = 8'h5A;
        exp_stat("t2_gap", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        in_last = 1'b0;
      end
    end
    exp_stat("t2_run", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt("t2_cnt", 8);
    exp_word("t2_w0", 8'd0, 32'hE2110000);
    exp_word("t2_w4", 8'd4, 32'hE0805183);

    // Exact fill
    tick();
    do_start();
    for (int i = 0; i < 256; i++) send(8'(i), i == 255);
    exp_stat("t3_run", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt("t3_cnt", 256);
    exp_word("t3_wrap", 8'd255, 32'hFF000102);
    exp_word("t3_w0", 8'd0, 32'h00010203);
    exp_word("t3_w128", 8'd128, model_word(8'd128));

    // Overflow then recovery
    tick();
    do_start();
    for (int i = 0; i < 256; i++) send(8'(255 - i), 1'b0);
    exp_stat("t4_err", 1'b0, 1'b1, 1'b0, 1'b1);
    exp_cnt("t4_cnt", 256);
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    tick();
    in_valid = 1'b0;
    exp_stat("t4_err_hold", 1'b0, 1'b1, 1'b0, 1'b1);
    exp_cnt("t4_cnt_hold", 256);
    exp_word("t4_w0", 8'd0, 32'hFFFEFDFC);
    do_start();
    exp_stat("t4_reload", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t4_recnt0", 0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    exp_stat("t4_run", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt("t4_recnt", 4);
    exp_word("t4_rw0", 8'd0, 32'h11223344);
    exp_word("t4_rw4", 8'd4, 32'hFBFAF9F8);

    // Reset mid-load, colliding with a 4th byte
    tick();
    do_start();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hDD;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    exp_stat("t5_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    exp_cnt("t5_cnt", 0);
    exp_word("t5_w0", 8'd0, 32'hAABBCC44);
    exp_word("t5_model", 8'd0, model_word(8'd0));

    // Reload from RUN, start pulse inside LOAD
    do_start();
    for (int i = 0; i < 8; i++) send(prog[i], i == 7);
    exp_stat("t6_run1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    do_start();
    exp_stat("t6_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_stat("t6_midstart", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("t6_midcnt", 2);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    exp_stat("t6_run2", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt("t6_cnt", 4);
    exp_word("t6_w0", 8'd0, 32'h00000000);
    exp_word("t6_w4", 8'd4, 32'hE0805183);
    exp_word("t6_w8", 8'd8, 32'hF7F6F5F4);

    tick();
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
